pwm_capture: RTL and testbench
==============================

# pwm_capture

PWM capture/decoder: samples an asynchronous PWM waveform and measures its period and high time in `clk` cycles. It is the receive-side counterpart of the team's PWM generator and sits at the input of a control path (fan tach, servo feedback, loopback checks). One measurement is reported per full rising-edge-to-rising-edge interval. A constant-level input is flagged as stuck.

## Interface
- `WIDTH`, 16: width of counters and measurement outputs.
- `SYNC_STAGES`, 2: flop stages in the input synchronizer (≥2).
- `TIMEOUT`, 2**WIDTH-1: cycles without a qualifying edge before stuck is declared (≤ 2**WIDTH-1).

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: capture enable.
- `pwm_in`, in, 1: asynchronous PWM input.
- `period_out`, out, WIDTH: last measured period in cycles.
- `duty_out`, out, WIDTH: last measured high time in cycles.
- `valid`, out, 1: one-cycle pulse; `period_out`/`duty_out` updated this cycle.
- `stuck`, out, 1: input has had no edge for `TIMEOUT` cycles.
- `stuck_level`, out, 1: level of the input when `stuck` was set.

## Operation
- `s` is the synchronized input and `s_d` is `s` delayed one cycle. `rise = s & ~s_d` and `fall = ~s & s_d`.
- States:
  - IDLE: entered when `enable` is 0. `cnt` is 0 and `stuck` is cleared. Outputs hold.
  - ARM: waits for the first `rise`. Any partial period is discarded. `cnt` increments each cycle.
  - HIGH and LOW: measuring.
- Transitions:
  - IDLE→ARM: `enable`=1.
  - Any state→IDLE: `enable`=0, with priority over everything else.
  - ARM→HIGH on `rise`: `cnt`←1, `stuck`←0.
  - HIGH→LOW on `fall`: `hi_cnt`←`cnt`, `cnt`←`cnt`+1.
  - LOW→HIGH on `rise`: `period_out`←`cnt`, `duty_out`←`hi_cnt`, `valid`←1, `cnt`←1.
  - In HIGH and LOW with no edge: `cnt`←`cnt`+1.
- Timeout: in ARM, HIGH or LOW, if `cnt` reaches `TIMEOUT` with no edge that cycle:
  - `stuck`←1 and `stuck_level`←`s`.
  - Go to ARM with `cnt`←0.
  - No `valid` is produced, and `period_out`/`duty_out` hold.
- `stuck` remains set until the next `rise` or IDLE.
- An edge and the timeout in the same cycle: the edge wins.
- Counter arithmetic is unsigned WIDTH bits. `cnt` never wraps because timeout fires first.
- Results:
  - `period_out` = P, the cycle count from rise to rise.
  - `duty_out` = D, the high cycles.
  - Duty 0% or 100% yields `stuck` with `stuck_level` 0 or 1 respectively.
- Input high or low phases shorter than one `clk` cycle may be lost. Minimum measurable values are D=1 and P=2.

## Timing
- Reset values:
  - `period_out`, `duty_out`, `cnt`, `hi_cnt`: 0.
  - `valid`, `stuck`, `stuck_level`: 0.
  - State: IDLE.
  - Synchronizer flops: 0.
- Latency: let k be the first clk edge that samples `pwm_in`=1 at the start of the next period. `valid` is high for the cycle after edge k+`SYNC_STAGES`.
- `valid` is never high two cycles in a row. For a steady input it pulses every P cycles.
- After `enable` rises, the first `valid` appears at the second detected `rise`.
- Period or duty change mid-stream: the interval containing the change reports mixed values. The following interval reports the new values exactly.
- Reset mid-measurement: everything returns to reset values immediately. No `valid` is produced for the interrupted interval.

## Structure
- Package `pwm_pkg`:
  - State enum (IDLE, ARM, HIGH, LOW).
  - Default `WIDTH` constant, shared with the generator.
- Sub-module `pwm_sync_edge`:
  - `SYNC_STAGES` synchronizer and `s_d` register.
  - Outputs `s`, `rise`, `fall`.
- `pwm_capture` holds the FSM, the counters and the output registers.

## Test plan
- Loopback from the generator with period=10, duty=3, `enable`=1: after the first discarded interval, `valid` pulses every 10 cycles with `period_out`=10 and `duty_out`=3. `stuck` stays 0.
- `TIMEOUT`=100 and generator duty=0: after 100 cycles, `stuck`=1 and `stuck_level`=0, with no `valid`. Then set duty=4, period=8: the next `rise` clears `stuck`, followed by `valid` with 8/4.
- Duty=20, period=10 (constant high): `stuck`=1 and `stuck_level`=1 after `TIMEOUT` cycles.
- Change from period=10/duty=3 to period=25/duty=12 mid-stream: at most one mixed result, then a steady 25/12.
- `rst_n` pulsed low during HIGH: all outputs are 0 immediately, and measurement restarts from IDLE/ARM.
- `enable` deasserted mid-LOW: no `valid`, outputs hold last values, `stuck` clears. On re-enable, the first `valid` comes after two rises.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: types and constants shared by the PWM capture block and the
// PWM generator.
//   PWM_WIDTH   : default counter / measurement width
//   pwm_state_e : capture FSM states
package pwm_pkg;

  // Default counter width, kept in step with the generator.
  localparam int PWM_WIDTH = 16;

  // Capture FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } pwm_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: brings the asynchronous PWM input into the clk domain and
// detects its edges.
//   clk, rst_n : clock, asynchronous active-low reset
//   pwm_in     : asynchronous PWM input
//   s          : synchronized input level
//   rise, fall : single-cycle edge strobes derived from s and s delayed
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_d_r;

  // Synchronizer chain plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      s_d_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pwm_in};
      s_d_r  <= sync_r[SYNC_STAGES-1];
    end
  end

  assign s    = sync_r[SYNC_STAGES-1];
  assign rise = s & ~s_d_r;
  assign fall = ~s & s_d_r;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input
// in clk cycles, one result per rise-to-rise interval, and flags a input
// that has stopped toggling.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : capture enable (0 forces IDLE)
//   pwm_in      : asynchronous PWM input
//   period_out  : last measured period
//   duty_out    : last measured high time
//   valid       : one-cycle pulse when period_out/duty_out update
//   stuck       : no qualifying edge for TIMEOUT cycles
//   stuck_level : synchronized input level when stuck was raised
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] duty_out,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);

  logic             s_s;
  logic             rise_s;
  logic             fall_s;
  logic             timeout_s;

  pwm_state_e       state_r;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] hi_cnt_r;
  logic [WIDTH-1:0] period_r;
  logic [WIDTH-1:0] duty_r;
  logic             valid_r;
  logic             stuck_r;
  logic             stuck_level_r;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (pwm_in),
    .s      (s_s),
    .rise   (rise_s),
    .fall   (fall_s)
  );

  // The counter is checked before incrementing, so it stops at TIMEOUT and
  // can never wrap.
  assign timeout_s = (cnt_r == TIMEOUT_C);

  // Capture FSM, interval counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= CNT_ZERO;
      hi_cnt_r      <= CNT_ZERO;
      period_r      <= CNT_ZERO;
      duty_r        <= CNT_ZERO;
      valid_r       <= 1'b0;
      stuck_r       <= 1'b0;
      stuck_level_r <= 1'b0;
    end else if (!enable) begin
      // Disable overrides everything; measurements hold.
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      valid_r <= 1'b0;
      stuck_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          state_r <= ARM;
          cnt_r   <= CNT_ZERO;
        end
        ARM: begin
          // The first rise only starts an interval; nothing before it counts.
          if (rise_s) begin
            state_r <= HIGH;
            cnt_r   <= CNT_ONE;
            stuck_r <= 1'b0;
          end else if (timeout_s) begin
            cnt_r         <= CNT_ZERO;
            stuck_r       <= 1'b1;
            stuck_level_r <= s_s;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        HIGH: begin
          // A rise cannot be seen here: reaching HIGH needs s=1, and a rise
          // needs a preceding fall, which leaves HIGH first.
          if (fall_s) begin
            state_r  <= LOW;
            hi_cnt_r <= cnt_r;
            cnt_r    <= cnt_r + CNT_ONE;
          end else if (timeout_s) begin
            state_r       <= ARM;
            cnt_r         <= CNT_ZERO;
            stuck_r       <= 1'b1;
            stuck_level_r <= s_s;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        LOW: begin
          if (rise_s) begin
            state_r  <= HIGH;
            period_r <= cnt_r;
            duty_r   <= hi_cnt_r;
            valid_r  <= 1'b1;
            cnt_r    <= CNT_ONE;
          end else if (timeout_s) begin
            state_r       <= ARM;
            cnt_r         <= CNT_ZERO;
            stuck_r       <= 1'b1;
            stuck_level_r <= s_s;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign period_out  = period_r;
  assign duty_out    = duty_r;
  assign valid       = valid_r;
  assign stuck       = stuck_r;
  assign stuck_level = stuck_level_r;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture with a behavioural PWM
// source; results are compared against hand-computed values.
module tb_pwm_capture;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        pwm_in;
  logic [15:0] period_out;
  logic [15:0] duty_out;
  logic        valid;
  logic        stuck;
  logic        stuck_level;

  int n_tests;
  int n_fail;

  // Generator phase and observation log.
  int          gen_ph;
  int          cyc;
  int          consec;
  logic        prev_valid;
  int          vq_t[$];
  int          vq_p[$];
  int          vq_d[$];
  int          rq_t[$];

  pwm_capture #(
    .WIDTH       (16),
    .SYNC_STAGES (2),
    .TIMEOUT     (100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .pwm_in      (pwm_in),
    .period_out  (period_out),
    .duty_out    (duty_out),
    .valid       (valid),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_log();
    vq_t.delete();
    vq_p.delete();
    vq_d.delete();
    rq_t.delete();
  endtask

  // Runs n cycles of the PWM source; samples outputs on the falling edge
  // before driving the next input level.
  task automatic drive(input int per, input int duty, input int n);
    logic nxt;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (valid === 1'b1) begin
        vq_t.push_back(cyc);
        vq_p.push_back(int'(period_out));
        vq_d.push_back(int'(duty_out));
        if (prev_valid === 1'b1) consec++;
      end
      prev_valid = valid;
      nxt = (gen_ph < duty);
      if (nxt && !pwm_in) rq_t.push_back(cyc);
      pwm_in = nxt;
      gen_ph = (gen_ph + 1) % per;
    end
  endtask

  task automatic drive_until_ph(input int per, input int duty, input int ph);
    while (gen_ph != ph) drive(per, duty, 1);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (period_out !== 16'd0) begin n_fail++; $display("FAIL reset_period: got %0d expected 0", period_out); end
    n_tests++; if (duty_out !== 16'd0) begin n_fail++; $display("FAIL reset_duty: got %0d expected 0", duty_out); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_tests++; if (stuck !== 1'b0) begin n_fail++; $display("FAIL reset_stuck: got %b expected 0", stuck); end
    n_tests++; if (stuck_level !== 1'b0) begin n_fail++; $display("FAIL reset_stuck_level: got %b expected 0", stuck_level); end
    rst_n = 1'b1;
  endtask

  task automatic test_loopback();
    gen_ph = 0;
    enable = 1'b1;
    clear_log();
    drive(10, 3, 100);
    n_tests++; if (vq_t.size() < 8) begin n_fail++; $display("FAIL loop_count: got %0d expected >= 8", vq_t.size()); end
    for (int i = 0; i < vq_t.size(); i++) begin
      n_tests++; if (vq_p[i] != 10 || vq_d[i] != 3) begin n_fail++; $display("FAIL loop_value[%0d]: got %0d/%0d expected 10/3", i, vq_p[i], vq_d[i]); end
      if (i > 0) begin
        n_tests++; if (vq_t[i] - vq_t[i-1] != 10) begin n_fail++; $display("FAIL loop_spacing[%0d]: got %0d expected 10", i, vq_t[i] - vq_t[i-1]); end
      end
    end
    n_tests++; if (consec != 0) begin n_fail++; $display("FAIL loop_consec: got %0d expected 0", consec); end
    n_tests++; if (stuck !== 1'b0) begin n_fail++; $display("FAIL loop_stuck: got %b expected 0", stuck); end
  endtask

  task automatic test_stuck_low();
    enable = 1'b0;
    gen_ph = 0;
    drive(8, 0, 6);
    enable = 1'b1;
    clear_log();
    drive(8, 0, 90);
    n_tests++; if (stuck !== 1'b0) begin n_fail++; $display("FAIL stuck_early: got %b expected 0", stuck); end
    drive(8, 0, 20);
    n_tests++; if (stuck !== 1'b1) begin n_fail++; $display("FAIL stuck_low: got %b expected 1", stuck); end
    n_tests++; if (stuck_level !== 1'b0) begin n_fail++; $display("FAIL stuck_low_level: got %b expected 0", stuck_level); end
    n_tests++; if (vq_t.size() != 0) begin n_fail++; $display("FAIL stuck_low_novalid: got %0d expected 0", vq_t.size()); end
    n_tests++; if (period_out !== 16'd10 || duty_out !== 16'd3) begin n_fail++; $display("FAIL stuck_low_hold: got %0d/%0d expected 10/3", period_out, duty_out); end
    gen_ph = 0;
    clear_log();
    drive(8, 4, 6);
    n_tests++; if (stuck !== 1'b0) begin n_fail++; $display("FAIL stuck_clear: got %b expected 0", stuck); end
    drive(8, 4, 30);
    n_tests++; if (vq_t.size() < 2) begin n_fail++; $display("FAIL recover_count: got %0d expected >= 2", vq_t.size()); end
    for (int i = 0; i < vq_t.size(); i++) begin
      n_tests++; if (vq_p[i] != 8 || vq_d[i] != 4) begin n_fail++; $display("FAIL recover_value[%0d]: got %0d/%0d expected 8/4", i, vq_p[i], vq_d[i]); end
    end
  endtask

  task automatic test_stuck_high();
    drive(10, 20, 12);
    clear_log();
    drive(10, 20, 130);
    n_tests++; if (stuck !== 1'b1) begin n_fail++; $display("FAIL stuck_high: got %b expected 1", stuck); end
    n_tests++; if (stuck_level !== 1'b1) begin n_fail++; $display("FAIL stuck_high_level: got %b expected 1", stuck_level); end
    n_tests++; if (vq_t.size() != 0) begin n_fail++; $display("FAIL stuck_high_novalid: got %0d expected 0", vq_t.size()); end
  endtask

  task automatic test_change();
    drive(10, 3, 60);
    n_tests++; if (stuck !== 1'b0) begin n_fail++; $display("FAIL change_unstuck: got %b expected 0", stuck); end
    // Switch exactly at a period boundary so the last old interval is whole.
    drive_until_ph(10, 3, 0);
    clear_log();
    drive(25, 12, 150);
    n_tests++; if (vq_t.size() < 5) begin n_fail++; $display("FAIL change_count: got %0d expected >= 5", vq_t.size()); end
    if (vq_t.size() > 0) begin
      n_tests++; if (vq_p[0] != 10 || vq_d[0] != 3) begin n_fail++; $display("FAIL change_first: got %0d/%0d expected 10/3", vq_p[0], vq_d[0]); end
    end
    for (int i = 1; i < vq_t.size(); i++) begin
      n_tests++; if (vq_p[i] != 25 || vq_d[i] != 12) begin n_fail++; $display("FAIL change_value[%0d]: got %0d/%0d expected 25/12", i, vq_p[i], vq_d[i]); end
      n_tests++; if (vq_t[i] - vq_t[i-1] != 25) begin n_fail++; $display("FAIL change_spacing[%0d]: got %0d expected 25", i, vq_t[i] - vq_t[i-1]); end
    end
  endtask

  task automatic test_reset_mid();
    drive_until_ph(25, 12, 5);
    rst_n = 1'b0;
    #1;
    n_tests++; if (period_out !== 16'd0 || duty_out !== 16'd0) begin n_fail++; $display("FAIL rstmid_meas: got %0d/%0d expected 0/0", period_out, duty_out); end
    n_tests++; if (valid !== 1'b0 || stuck !== 1'b0 || stuck_level !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got %b%b%b expected 000", valid, stuck, stuck_level); end
    drive(25, 12, 3);
    rst_n = 1'b1;
    clear_log();
    drive(25, 12, 100);
    n_tests++; if (vq_t.size() < 2) begin n_fail++; $display("FAIL rstmid_count: got %0d expected >= 2", vq_t.size()); end
    if (vq_t.size() > 0) begin
      n_tests++; if (vq_p[vq_t.size()-1] != 25 || vq_d[vq_t.size()-1] != 12) begin n_fail++; $display("FAIL rstmid_value: got %0d/%0d expected 25/12", vq_p[vq_t.size()-1], vq_d[vq_t.size()-1]); end
    end
  endtask

  task automatic test_enable_drop();
    drive_until_ph(25, 12, 20);
    enable = 1'b0;
    clear_log();
    drive(25, 12, 60);
    n_tests++; if (vq_t.size() != 0) begin n_fail++; $display("FAIL endrop_novalid: got %0d expected 0", vq_t.size()); end
    n_tests++; if (period_out !== 16'd25 || duty_out !== 16'd12) begin n_fail++; $display("FAIL endrop_hold: got %0d/%0d expected 25/12", period_out, duty_out); end
    n_tests++; if (stuck !== 1'b0) begin n_fail++; $display("FAIL endrop_stuck: got %b expected 0", stuck); end
    drive_until_ph(25, 12, 15);
    enable = 1'b1;
    clear_log();
    drive(25, 12, 80);
    n_tests++; if (vq_t.size() < 1 || rq_t.size() < 2) begin
      n_fail++; $display("FAIL reen_count: got %0d valids %0d rises expected >= 1 and >= 2", vq_t.size(), rq_t.size());
    end else begin
      // Input rise driven at cycle c shows as valid at cycle c+3.
      n_tests++; if (vq_t[0] != rq_t[1] + 3) begin n_fail++; $display("FAIL reen_latency: got %0d expected %0d", vq_t[0], rq_t[1] + 3); end
      n_tests++; if (vq_p[0] != 25 || vq_d[0] != 12) begin n_fail++; $display("FAIL reen_value: got %0d/%0d expected 25/12", vq_p[0], vq_d[0]); end
    end
    n_tests++; if (consec != 0) begin n_fail++; $display("FAIL final_consec: got %0d expected 0", consec); end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    gen_ph     = 0;
    cyc        = 0;
    consec     = 0;
    prev_valid = 1'b0;
    rst_n      = 1'b0;
    enable     = 1'b0;
    pwm_in     = 1'b0;
    test_reset();
    test_loopback();
    test_stuck_low();
    test_stuck_high();
    test_change();
    test_reset_mid();
    test_enable_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
